// File: rtl/riscv_csr_unit.sv
// Machine-mode CSR unit: a two-state access engine (accept, then respond and
// commit), trap/MRET state save and restore, and the 64-bit cycle and
// instret counters with their user-mode read-only mirrors.
module riscv_csr_unit #(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  // Access port from ID/EX
  input  logic        csr_req_i,
  output logic        csr_ready_o,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_rvalid_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  // Trap entry / return
  input  logic        exc_save_i,
  input  logic [31:0] exc_pc_i,
  input  logic [5:0]  exc_cause_i,
  input  logic        mret_i,
  input  logic        instr_ret_i,
  // Registered state
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o,
  output logic        irq_enable_o
);

  typedef enum logic [1:0] {
    CsrOpNone  = 2'd0,
    CsrOpWrite = 2'd1,
    CsrOpSet   = 2'd2,
    CsrOpClear = 2'd3
  } csr_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrCycle     = 12'hC00;
  localparam logic [11:0] CsrInstret   = 12'hC02;
  localparam logic [11:0] CsrCycleh    = 12'hC80;
  localparam logic [11:0] CsrInstreth  = 12'hC82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  // Access engine state
  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  csr_op_e     op_q, op_d;
  logic [31:0] wdata_q, wdata_d;

  // Architectural state; constant-zero bits are not stored
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:1] mepc_q, mepc_d;
  logic        mcause_irq_q, mcause_irq_d;
  logic [4:0]  mcause_code_q, mcause_code_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        resp;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic        legal;
  logic        wr_en;
  logic [31:0] new_val;

  // Bit 0 of the trap PC is never stored
  logic        unused_exc_pc0;
  assign unused_exc_pc0 = exc_pc_i[0];

  assign resp = (state_q == StResp);

  // Read mux over the latched address; also flags unmapped addresses
  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (addr_q)
      CsrMstatus:              rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      CsrMtvec:                rd_val = {mtvec_q, 2'b00};
      CsrMscratch:             rd_val = mscratch_q;
      CsrMepc:                 rd_val = {mepc_q, 1'b0};
      CsrMcause:               rd_val = {mcause_irq_q, 26'b0, mcause_code_q};
      CsrMcycle,   CsrCycle:   rd_val = mcycle_q[31:0];
      CsrMcycleh,  CsrCycleh:  rd_val = mcycle_q[63:32];
      CsrMinstret, CsrInstret: rd_val = minstret_q[31:0];
      CsrMinstreth, CsrInstreth: rd_val = minstret_q[63:32];
      CsrMhartid:              rd_val = HART_ID;
      default:                 rd_hit = 1'b0;
    endcase
  end

  // Writes to the 0xC00-0xFFF range are read-only violations
  assign legal = rd_hit && !((op_q != CsrOpNone) && (addr_q[11:10] == 2'b11));
  assign wr_en = resp && legal && (op_q != CsrOpNone);

  // Read-modify-write value for the pending access
  always_comb begin
    new_val = rd_val;
    unique case (op_q)
      CsrOpWrite: new_val = wdata_q;
      CsrOpSet:   new_val = rd_val | wdata_q;
      CsrOpClear: new_val = rd_val & ~wdata_q;
      CsrOpNone:  new_val = rd_val;
      default:    new_val = rd_val;
    endcase
  end

  // Access FSM next state, request latching and response outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    csr_ready_o  = 1'b0;
    csr_rvalid_o = 1'b0;
    csr_err_o    = 1'b0;
    csr_rdata_o  = '0;
    unique case (state_q)
      StIdle: begin
        csr_ready_o = 1'b1;
        if (csr_req_i) begin
          addr_d  = csr_addr_i;
          op_d    = csr_op_e'(csr_op_i);
          wdata_d = csr_wdata_i;
          state_d = StResp;
        end
      end
      StResp: begin
        csr_rvalid_o = 1'b1;
        csr_err_o    = !legal;
        csr_rdata_o  = legal ? rd_val : '0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // CSR next state: counters tick, then CSR write, then MRET, then trap;
  // later assignments win so a trap or MRET drops a colliding CSR write
  always_comb begin
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_irq_d  = mcause_irq_q;
    mcause_code_d = mcause_code_q;
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = instr_ret_i ? minstret_q + 64'd1 : minstret_q;

    if (wr_en) begin
      case (addr_q)
        CsrMstatus: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        CsrMtvec:     mtvec_d    = new_val[31:2];
        CsrMscratch:  mscratch_d = new_val;
        CsrMepc:      mepc_d     = new_val[31:1];
        CsrMcause: begin
          mcause_irq_d  = new_val[31];
          mcause_code_d = new_val[4:0];
        end
        // A half-write replaces that half and suppresses the increment
        CsrMcycle:    mcycle_d   = {mcycle_q[63:32], new_val};
        CsrMcycleh:   mcycle_d   = {new_val, mcycle_q[31:0]};
        CsrMinstret:  minstret_d = {minstret_q[63:32], new_val};
        CsrMinstreth: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end

    if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (exc_save_i) begin
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      mepc_d        = exc_pc_i[31:1];
      mcause_irq_d  = exc_cause_i[5];
      mcause_code_d = exc_cause_i[4:0];
    end
  end

  // State registers with synchronous reset; reset in RESP aborts the access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      op_q          <= CsrOpNone;
      wdata_q       <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RST[31:2];
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_irq_q  <= 1'b0;
      mcause_code_q <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      op_q          <= op_d;
      wdata_q       <= wdata_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_irq_q  <= mcause_irq_d;
      mcause_code_q <= mcause_code_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  assign mepc_o       = {mepc_q, 1'b0};
  assign mtvec_o      = {mtvec_q, 2'b00};
  assign irq_enable_o = mie_q;

endmodule
